// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF      = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, status decode and error pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  full,
    output logic                  over,
    output logic                  under
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, over_q, under_q;
    logic          wr_ok, rd_ok;

    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_CNT);
    assign almostfull = (count_q >= AFULL_CNT);

    // A write into a full FIFO still succeeds when a read frees a slot on the same edge.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= rd_ok;
            over_q  <= wr && !wr_ok;
            under_q <= rd && !rd_ok;
        end
    end

    assign valid = valid_q;
    assign over  = over_q;
    assign under = under_q;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr_q),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rptr_q),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic vs a queue model.
module tb_sync_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFULL = DEPTH - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          valid, empty, almostfull, full, over, under;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout  = '0;
    logic          exp_valid = 1'b0;
    logic          exp_over  = 1'b0;
    logic          exp_under = 1'b0;

    sync_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .rd         (rd),
        .din        (din),
        .dout       (dout),
        .valid      (valid),
        .empty      (empty),
        .almostfull (almostfull),
        .full       (full),
        .over       (over),
        .under      (under)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  32'(dout),       32'(exp_dout));
        chk({tag, ".valid"}, 32'(valid),      32'(exp_valid));
        chk({tag, ".empty"}, 32'(empty),      32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),       32'(q.size() == DEPTH));
        chk({tag, ".afull"}, 32'(almostfull), 32'(q.size() >= AFULL));
        chk({tag, ".over"},  32'(over),       32'(exp_over));
        chk({tag, ".under"}, 32'(under),      32'(exp_under));
    endtask

    // One clock of traffic; the model applies the FIFO rules to its own queue.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit was_full, was_empty, r_ok, w_ok;
        wr = w;
        rd = r;
        din = d;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        r_ok = r && !was_empty;
        w_ok = w && (!was_full || r);
        @(posedge clk);
        #1;
        exp_valid = r_ok;
        if (r_ok) exp_dout = q.pop_front();
        if (w_ok) q.push_back(d);
        exp_over  = w && !w_ok;
        exp_under = r && !r_ok;
        check_all(tag);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        // Reset held for 10 cycles.
        repeat (10) @(posedge clk);
        #1;
        check_all("reset");
        #3;
        rst = 1'b1;

        // Fill with 1..9; the 9th overflows.
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, DW'(i), "fill");
            if (i == 7) begin
                chk("afull_at_7", 32'(almostfull), 32'd1);
                chk("notfull_at_7", 32'(full), 32'd0);
            end
            if (i == 8) chk("full_at_8", 32'(full), 32'd1);
            if (i == 9) chk("over_at_9", 32'(over), 32'd1);
        end
        step(1'b0, 1'b0, '0, "over_clear");
        chk("over_pulse_done", 32'(over), 32'd0);

        // Drain 9 reads; the 9th underflows.
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            if (i == 1) chk("full_drop", 32'(full), 32'd0);
            if (i <= 8) chk("drain_order", 32'(dout), 32'(i));
            if (i == 8) chk("empty_at_8", 32'(empty), 32'd1);
            if (i == 9) begin
                chk("under_at_9", 32'(under), 32'd1);
                chk("dout_hold", 32'(dout), 32'd8);
                chk("valid_low", 32'(valid), 32'd0);
            end
        end

        // Simultaneous read and write while full.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i), "refill");
        step(1'b1, 1'b1, 16'hAAAA, "both_full");
        chk("both_full_pop", 32'(dout), 32'd1);
        chk("both_full_noover", 32'(over), 32'd0);
        chk("both_full_still", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "drain_aaaa");
        chk("last_aaaa", 32'(dout), 32'hAAAA);

        // Simultaneous read and write while empty: write only, under pulses.
        step(1'b1, 1'b1, 16'h1234, "both_empty");
        chk("both_empty_under", 32'(under), 32'd1);

        // Streaming across pointer wrap.
        step(1'b1, 1'b0, DW'($urandom), "prime");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom), "stream");
        while (q.size() != 0) step(1'b0, 1'b1, '0, "stream_drain");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 DW'($urandom), "rand");
        end

        // Reset mid-stream with 5 entries stored.
        while (q.size() != 0) step(1'b0, 1'b1, '0, "pre_rst_drain");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), "pre_rst_fill");
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
        chk("rst_async_empty", 32'(empty), 32'd1);
        check_all("rst_mid");
        @(posedge clk);
        #3;
        rst = 1'b1;
        step(1'b0, 1'b1, '0, "after_rst_rd");
        chk("after_rst_under", 32'(under), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
